// File: rtl/instr_sequencer_pkg.sv
// Shared definitions for the instruction sequencer: FSM encoding, long-instruction flag index
// and the interrupt vector table layout shared with the assembler.
package instr_sequencer_pkg;

  typedef enum logic [2:0] {
    SEQ_IDLE,
    SEQ_FETCH,
    SEQ_WAIT_MEM,
    SEQ_ISSUE,
    SEQ_EXEC
  } seq_state_e;

  localparam int unsigned DEF_WIDTH           = 32;
  localparam int unsigned DEF_INT_BASE        = 32'h0000_0010;
  localparam int unsigned DEF_INT_STRIDE_LOG2 = 1;

  // Top bit of the instruction word marks a long instruction.
  function automatic int unsigned long_bit(input int unsigned width);
    return width - 1;
  endfunction

endpackage

// File: rtl/instr_sequencer.sv
// Fetch/issue controller: owns the PC, fetches words over a req/valid handshake and issues
// each word to the decoder as one long instruction or two short halves (high half first).
module instr_sequencer
  import instr_sequencer_pkg::*;
#(
  parameter int unsigned           WIDTH           = DEF_WIDTH,
  parameter int unsigned           ADDR_WIDTH      = 16,
  parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR    = '0,
  parameter int unsigned           INT_NUM         = 3,
  parameter logic [ADDR_WIDTH-1:0] INT_BASE        = ADDR_WIDTH'(DEF_INT_BASE),
  parameter int unsigned           INT_STRIDE_LOG2 = DEF_INT_STRIDE_LOG2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  run,
  output logic                  mem_rd_req,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [WIDTH-1:0]      mem_rd_data,
  input  logic                  mem_rd_valid,
  output logic [WIDTH-1:0]      long_instr,
  output logic                  instr_choose,
  output logic                  dec_en,
  input  logic                  exec_busy,
  input  logic                  jump_taken,
  input  logic [ADDR_WIDTH-1:0] jump_addr,
  input  logic                  int_req,
  input  logic [INT_NUM-1:0]    int_num,
  output logic [ADDR_WIDTH-1:0] ret_addr,
  output logic [ADDR_WIDTH-1:0] pc
);

  localparam int unsigned LongBit = long_bit(WIDTH);

  seq_state_e            state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [ADDR_WIDTH-1:0] ret_q, ret_d;
  logic [WIDTH-1:0]      instr_q, instr_d;
  logic                  choose_q, choose_d;

  logic [ADDR_WIDTH-1:0] pc_inc, vec_addr, pc_next;
  logic                  low_pending;

  assign low_pending = !instr_q[LongBit] && !choose_q;

  // Next-PC mux: interrupt vector beats jump target beats sequential increment.
  always_comb begin
    pc_inc   = pc_q + ADDR_WIDTH'(1);
    vec_addr = INT_BASE + (ADDR_WIDTH'(int_num) << INT_STRIDE_LOG2);
    if (int_req) begin
      pc_next = vec_addr;
    end else if (jump_taken) begin
      pc_next = jump_addr;
    end else begin
      pc_next = pc_inc;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= SEQ_IDLE;
      pc_q     <= RESET_VECTOR;
      ret_q    <= '0;
      instr_q  <= '0;
      choose_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      ret_q    <= ret_d;
      instr_q  <= instr_d;
      choose_q <= choose_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    ret_d    = ret_q;
    instr_d  = instr_q;
    choose_d = choose_q;
    unique case (state_q)
      SEQ_IDLE: begin
        if (run) state_d = SEQ_FETCH;
      end
      SEQ_FETCH: begin
        state_d = SEQ_WAIT_MEM;
      end
      SEQ_WAIT_MEM: begin
        if (mem_rd_valid) begin
          instr_d  = mem_rd_data;
          choose_d = 1'b0;
          state_d  = SEQ_ISSUE;
        end
      end
      SEQ_ISSUE: begin
        state_d = SEQ_EXEC;
      end
      SEQ_EXEC: begin
        if (!exec_busy) begin
          // Redirects drop any pending low half; otherwise the low half issues without refetch.
          if (int_req || jump_taken || !low_pending) begin
            pc_d    = pc_next;
            state_d = run ? SEQ_FETCH : SEQ_IDLE;
            if (int_req) ret_d = pc_inc;
          end else begin
            choose_d = 1'b1;
            state_d  = SEQ_ISSUE;
          end
        end
      end
      default: begin
        state_d = SEQ_IDLE;
      end
    endcase
  end

  always_comb begin
    mem_rd_req   = (state_q == SEQ_FETCH) || (state_q == SEQ_WAIT_MEM);
    dec_en       = (state_q == SEQ_ISSUE);
    mem_addr     = pc_q;
    pc           = pc_q;
    ret_addr     = ret_q;
    long_instr   = instr_q;
    instr_choose = choose_q;
  end

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed bench for instr_sequencer: a small memory responder plus hand-computed expectations
// for issue order, redirects, stalls, PC wrap and reset behaviour.
module tb_instr_sequencer;

  logic        clk;
  logic        reset;
  logic        run;
  logic        mem_rd_req;
  logic [15:0] mem_addr;
  logic [31:0] mem_rd_data;
  logic        mem_rd_valid;
  logic [31:0] long_instr;
  logic        instr_choose;
  logic        dec_en;
  logic        exec_busy;
  logic        jump_taken;
  logic [15:0] jump_addr;
  logic        int_req;
  logic [2:0]  int_num;
  logic [15:0] ret_addr;
  logic [15:0] pc;

  int n_vec   = 0;
  int n_err   = 0;
  int cyc     = 0;
  int dec_cnt = 0;
  int mem_lat = 2;

  instr_sequencer dut (
    .clk          (clk),
    .reset        (reset),
    .run          (run),
    .mem_rd_req   (mem_rd_req),
    .mem_addr     (mem_addr),
    .mem_rd_data  (mem_rd_data),
    .mem_rd_valid (mem_rd_valid),
    .long_instr   (long_instr),
    .instr_choose (instr_choose),
    .dec_en       (dec_en),
    .exec_busy    (exec_busy),
    .jump_taken   (jump_taken),
    .jump_addr    (jump_addr),
    .int_req      (int_req),
    .int_num      (int_num),
    .ret_addr     (ret_addr),
    .pc           (pc)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (dec_en) dec_cnt <= dec_cnt + 1;

  function automatic logic [31:0] mem_word(input logic [15:0] a);
    case (a)
      16'h0000: return 32'h0000_0000;
      16'h0001: return 32'h8000_1234;
      16'h0002: return 32'h0000_5678;
      16'h0003: return 32'h0000_0001;
      16'h0005: return 32'h0000_0002;
      16'h0016: return 32'h8000_0016;
      16'h0040: return 32'h8000_0040;
      16'hFFFF: return 32'h8000_FFFF;
      default:  return 32'h8000_0000;
    endcase
  endfunction

  // Memory responder: answers a held request after mem_lat cycles of req.
  initial begin
    int cnt;
    cnt = 0;
    mem_rd_valid = 1'b0;
    mem_rd_data  = '0;
    forever begin
      @(posedge clk);
      #1;
      mem_rd_valid = 1'b0;
      if (reset || !mem_rd_req) begin
        cnt = 0;
      end else begin
        cnt++;
        if (cnt >= mem_lat) begin
          mem_rd_valid = 1'b1;
          mem_rd_data  = mem_word(mem_addr);
          cnt = 0;
        end
      end
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic wait_issue(input string tag, input logic exp_choose, output int at);
    bit seen;
    int i;
    seen = 1'b0;
    i    = 0;
    at   = -1;
    while (!seen && i < 40) begin
      @(negedge clk);
      i++;
      if (dec_en) begin
        seen = 1'b1;
        at   = cyc;
      end
    end
    check_eq({tag, " dec_en seen"}, 32'(seen), 32'd1);
    if (seen) check_eq({tag, " instr_choose"}, 32'(instr_choose), 32'(exp_choose));
  endtask

  task automatic wait_fetch(input string tag, input logic [15:0] exp_addr);
    bit seen;
    int i;
    seen = mem_rd_req;
    i    = 0;
    while (!seen && i < 40) begin
      @(negedge clk);
      i++;
      seen = mem_rd_req;
    end
    check_eq({tag, " fetch seen"}, 32'(seen), 32'd1);
    if (seen) check_eq({tag, " mem_addr"}, 32'(mem_addr), 32'(exp_addr));
  endtask

  task automatic count_req(input int n, output int hits);
    hits = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (mem_rd_req) hits++;
    end
  endtask

  initial begin
    int t1, t2, base, hits;
    reset      = 1'b1;
    run        = 1'b1;
    exec_busy  = 1'b0;
    jump_taken = 1'b0;
    jump_addr  = '0;
    int_req    = 1'b0;
    int_num    = '0;

    repeat (2) @(negedge clk);
    check_eq("rst mem_rd_req", 32'(mem_rd_req), 32'd0);
    check_eq("rst dec_en", 32'(dec_en), 32'd0);
    check_eq("rst instr_choose", 32'(instr_choose), 32'd0);
    check_eq("rst long_instr", long_instr, 32'd0);
    check_eq("rst ret_addr", 32'(ret_addr), 32'd0);
    check_eq("rst pc", 32'(pc), 32'd0);
    reset = 1'b0;

    // Short pair at 0: high then low half, then fetch 1.
    base = dec_cnt;
    wait_fetch("w0", 16'h0000);
    wait_issue("w0 hi", 1'b0, t1);
    wait_issue("w0 lo", 1'b1, t1);
    wait_fetch("w0 next", 16'h0001);
    check_eq("w0 pulses", 32'(dec_cnt - base), 32'd2);

    // Long word at 1: single issue.
    base = dec_cnt;
    wait_issue("w1", 1'b0, t1);
    check_eq("w1 long_instr", long_instr, 32'h8000_1234);
    wait_fetch("w1 next", 16'h0002);
    check_eq("w1 pulses", 32'(dec_cnt - base), 32'd1);

    // Short pair at 2 with execute busy for three EXEC cycles after the high half.
    base = dec_cnt;
    wait_issue("w2 hi", 1'b0, t1);
    exec_busy = 1'b1;
    repeat (4) @(negedge clk);
    exec_busy = 1'b0;
    wait_issue("w2 lo", 1'b1, t2);
    check_eq("w2 stall gap", 32'(t2 - t1), 32'd5);
    wait_fetch("w2 next", 16'h0003);
    check_eq("w2 pulses", 32'(dec_cnt - base), 32'd2);

    // Jump from high half of word 3 drops the low half.
    base = dec_cnt;
    wait_issue("w3 hi", 1'b0, t1);
    jump_taken = 1'b1;
    jump_addr  = 16'h0040;
    repeat (2) @(negedge clk);
    jump_taken = 1'b0;
    wait_fetch("jump", 16'h0040);
    check_eq("jump pulses", 32'(dec_cnt - base), 32'd1);

    // Long word at 0x40 jumps to 5.
    wait_issue("w40", 1'b0, t1);
    jump_taken = 1'b1;
    jump_addr  = 16'h0005;
    repeat (2) @(negedge clk);
    jump_taken = 1'b0;
    wait_fetch("to 5", 16'h0005);

    // Interrupt 3 at pc 5 beats a simultaneous jump.
    base = dec_cnt;
    wait_issue("w5 hi", 1'b0, t1);
    int_req    = 1'b1;
    int_num    = 3'd3;
    jump_taken = 1'b1;
    jump_addr  = 16'h0040;
    repeat (2) @(negedge clk);
    int_req    = 1'b0;
    jump_taken = 1'b0;
    wait_fetch("int vec", 16'h0016);
    check_eq("int ret_addr", 32'(ret_addr), 32'h0006);
    check_eq("int pc", 32'(pc), 32'h0016);
    check_eq("int pulses", 32'(dec_cnt - base), 32'd1);

    // Jump to 0xFFFF, then sequential wrap to 0.
    wait_issue("w16", 1'b0, t1);
    jump_taken = 1'b1;
    jump_addr  = 16'hFFFF;
    repeat (2) @(negedge clk);
    jump_taken = 1'b0;
    wait_fetch("to ffff", 16'hFFFF);
    wait_issue("wffff", 1'b0, t1);
    wait_fetch("wrap", 16'h0000);
    wait_issue("wrap hi", 1'b0, t1);
    wait_issue("wrap lo", 1'b1, t1);
    wait_fetch("wrap next", 16'h0001);

    // Reset while waiting on memory: request drops without a clock edge.
    mem_lat = 10;
    @(negedge clk);
    check_eq("wait req", 32'(mem_rd_req), 32'd1);
    #2;
    reset = 1'b1;
    run   = 1'b0;
    #1;
    check_eq("async req drop", 32'(mem_rd_req), 32'd0);
    check_eq("async pc", 32'(pc), 32'h0000);
    check_eq("async ret_addr", 32'(ret_addr), 32'h0000);

    // Parked with run low, then run dropped mid-pair finishes the low half and idles.
    repeat (2) @(negedge clk);
    mem_lat = 2;
    reset   = 1'b0;
    count_req(4, hits);
    check_eq("idle no req", 32'(hits), 32'd0);
    run  = 1'b1;
    base = dec_cnt;
    wait_fetch("run w0", 16'h0000);
    wait_issue("run hi", 1'b0, t1);
    run = 1'b0;
    wait_issue("run lo", 1'b1, t1);
    count_req(6, hits);
    check_eq("parked no req", 32'(hits), 32'd0);
    check_eq("parked pc", 32'(pc), 32'h0001);
    check_eq("parked pulses", 32'(dec_cnt - base), 32'd2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
